adxl362_spi_model: RTL



---
 rtl/adxl362_spi_model.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/adxl362_spi_model.sv
// ADXL362 SPI slave model: oversampled mode-0 SPI, 64-byte register map,
// bench-injected XYZ samples with deferral while a transaction is open.
module adxl362_spi_model #(
    parameter logic [7:0] DEVID_AD  = 8'hAD,
    parameter logic [7:0] DEVID_MST = 8'h1D,
    parameter logic [7:0] PARTID    = 8'hF2,
    parameter logic [7:0] REVID     = 8'h01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    input  logic        sample_valid,
    input  logic [11:0] x_sample,
    input  logic [11:0] y_sample,
    input  logic [11:0] z_sample,
    output logic        data_ready,
    output logic        reg_write,
    output logic [5:0]  reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        cmd_error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_WDATA  = 3'd3;
    localparam logic [2:0] S_RDATA  = 3'd4;
    localparam logic [2:0] S_IGNORE = 3'd5;

    typedef logic [63:0][7:0] regmap_t;

    function automatic regmap_t reset_map();
        regmap_t r = '0;
        r[6'h00] = DEVID_AD;
        r[6'h01] = DEVID_MST;
        r[6'h02] = PARTID;
        r[6'h03] = REVID;
        r[6'h2C] = 8'h13;
        return r;
    endfunction

    function automatic regmap_t apply_sample(input regmap_t r,
                                             input logic [11:0] x,
                                             input logic [11:0] y,
                                             input logic [11:0] z);
        regmap_t m = r;
        m[6'h08] = x[11:4];
        m[6'h09] = y[11:4];
        m[6'h0A] = z[11:4];
        m[6'h0E] = x[7:0];
        m[6'h0F] = {{4{x[11]}}, x[11:8]};
        m[6'h10] = y[7:0];
        m[6'h11] = {{4{y[11]}}, y[11:8]};
        m[6'h12] = z[7:0];
        m[6'h13] = {{4{z[11]}}, z[11:8]};
        m[6'h0B][0] = 1'b1;
        return m;
    endfunction

    // [0]/[1] synchronizer stages, [2] previous synchronized value
    logic [2:0] sclk_sync_q;
    logic [2:0] cs_sync_q;
    logic [1:0] mosi_sync_q;
    logic       sclk_rise_q, sclk_fall_q, mosi_smp_q;

    logic [2:0] state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shin_q, shin_d;
    logic [7:0] shout_q, shout_d;
    logic [5:0] addr_q, addr_d;
    logic       wr_q, wr_d;
    logic       load_q, load_d;
    logic       miso_q, miso_d;
    logic       reg_write_q, reg_write_d;
    logic [5:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       cmd_error_q, cmd_error_d;
    logic       srst_q, srst_d;
    logic       pend_q, pend_d;
    logic [11:0] px_q, py_q, pz_q, px_d, py_d, pz_d;
    regmap_t    regs_q, regs_d;

    logic       cs_hi, cs_fall, cs_rise;
    logic [7:0] rx_byte, rd_data;

    assign cs_hi   = cs_sync_q[1];
    assign cs_fall = ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_rise = cs_sync_q[1] & ~cs_sync_q[2];
    assign rx_byte = {shin_q[6:0], mosi_smp_q};
    assign rd_data = regs_q[addr_q];

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shin_d      = shin_q;
        shout_d     = shout_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        load_d      = load_q;
        miso_d      = miso_q;
        reg_write_d = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        cmd_error_d = 1'b0;
        srst_d      = 1'b0;
        pend_d      = pend_q;
        px_d        = px_q;
        py_d        = py_q;
        pz_d        = pz_q;
        regs_d      = regs_q;

        if (cs_hi) begin
            state_d = S_IDLE;
            miso_d  = 1'b0;
            load_d  = 1'b0;
        end else if (cs_fall) begin
            state_d  = S_CMD;
            bitcnt_d = 3'd0;
            miso_d   = 1'b0;
            load_d   = 1'b0;
        end else if (state_q != S_IDLE) begin
            if (sclk_rise_q) begin
                shin_d   = rx_byte;
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    case (state_q)
                        S_CMD: begin
                            if (rx_byte == 8'h0A) begin
                                state_d = S_ADDR;
                                wr_d    = 1'b1;
                            end else if (rx_byte == 8'h0B) begin
                                state_d = S_ADDR;
                                wr_d    = 1'b0;
                            end else begin
                                state_d     = S_IGNORE;
                                cmd_error_d = 1'b1;
                            end
                        end
                        S_ADDR: begin
                            addr_d = rx_byte[5:0];
                            if (wr_q) begin
                                state_d = S_WDATA;
                            end else begin
                                state_d = S_RDATA;
                                load_d  = 1'b1;
                            end
                        end
                        S_WDATA: begin
                            reg_write_d = 1'b1;
                            reg_addr_d  = addr_q;
                            reg_wdata_d = rx_byte;
                            addr_d      = addr_q + 6'd1;
                            if (addr_q == 6'h1F) begin
                                srst_d = (rx_byte == 8'h52);
                            end else if (addr_q >= 6'h20 && addr_q <= 6'h2E) begin
                                regs_d[addr_q] = rx_byte;
                            end
                        end
                        S_RDATA: load_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            if (sclk_fall_q) begin
                if (state_q == S_RDATA && load_q) begin
                    miso_d  = rd_data[7];
                    shout_d = {rd_data[6:0], 1'b0};
                    addr_d  = addr_q + 6'd1;
                    load_d  = 1'b0;
                    if (addr_q == 6'h13) begin
                        regs_d[6'h0B][0] = 1'b0;
                    end
                end else if (state_q == S_RDATA) begin
                    miso_d  = shout_q[7];
                    shout_d = {shout_q[6:0], 1'b0};
                end else begin
                    miso_d = 1'b0;
                end
            end
        end

        // Sample application after the status clear so a new sample wins
        if (cs_rise && pend_q) begin
            regs_d = apply_sample(regs_d, px_q, py_q, pz_q);
            pend_d = 1'b0;
        end
        if (sample_valid) begin
            if (cs_hi) begin
                regs_d = apply_sample(regs_d, x_sample, y_sample, z_sample);
            end else begin
                pend_d = 1'b1;
                px_d   = x_sample;
                py_d   = y_sample;
                pz_d   = z_sample;
            end
        end
        if (srst_q) begin
            regs_d = reset_map();
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 3'b000;
            mosi_sync_q <= 2'b00;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            mosi_smp_q  <= 1'b0;
            state_q     <= S_IDLE;
            bitcnt_q    <= 3'd0;
            shin_q      <= 8'h00;
            shout_q     <= 8'h00;
            addr_q      <= 6'd0;
            wr_q        <= 1'b0;
            load_q      <= 1'b0;
            miso_q      <= 1'b0;
            reg_write_q <= 1'b0;
            reg_addr_q  <= 6'd0;
            reg_wdata_q <= 8'h00;
            cmd_error_q <= 1'b0;
            srst_q      <= 1'b0;
            pend_q      <= 1'b0;
            px_q        <= 12'h000;
            py_q        <= 12'h000;
            pz_q        <= 12'h000;
            regs_q      <= reset_map();
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            cs_sync_q   <= {cs_sync_q[1:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            sclk_rise_q <= sclk_sync_q[1] & ~sclk_sync_q[2];
            sclk_fall_q <= ~sclk_sync_q[1] & sclk_sync_q[2];
            mosi_smp_q  <= mosi_sync_q[1];
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shin_q      <= shin_d;
            shout_q     <= shout_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            load_q      <= load_d;
            miso_q      <= miso_d;
            reg_write_q <= reg_write_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            cmd_error_q <= cmd_error_d;
            srst_q      <= srst_d;
            pend_q      <= pend_d;
            px_q        <= px_d;
            py_q        <= py_d;
            pz_q        <= pz_d;
            regs_q      <= regs_d;
        end
    end

    assign miso       = miso_q;
    assign data_ready = regs_q[6'h0B][0];
    assign reg_write  = reg_write_q;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;
    assign cmd_error  = cmd_error_q;

endmodule
